// File: rtl/pipeline_seq_pkg.sv
// Shared types and helpers for the pipeline sequencer and its window timer.
package pipeline_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // Bit `pos` of a thermometer code with the low `n` bits set.
    function automatic logic therm_bit(input int unsigned pos, input int unsigned n);
        return pos < n;
    endfunction

endpackage

// File: rtl/window_timer.sv
// Free-running in-window cycle counter: counts 0..length-1 while enabled, flags the last cycle.
module window_timer #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] length,
    output logic [CNT_W-1:0] wcnt,
    output logic             last
);

    logic [CNT_W-1:0] wcnt_q;
    logic [CNT_W-1:0] wcnt_d;

    // length is guaranteed >= 1 by the caller
    assign last = (wcnt_q == length - CNT_W'(1));
    assign wcnt = wcnt_q;

    always_comb begin
        wcnt_d = wcnt_q;
        if (clear) begin
            wcnt_d = '0;
        end else if (enable) begin
            wcnt_d = last ? '0 : wcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Fill / run / drain sequencer for the link-test harness stage enables, with pause and abort.
module pipeline_sequencer
    import pipeline_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned CNT_W      = 11,
    parameter int unsigned WIN_W      = 16,
    parameter int unsigned TRIG_START = 1,
    parameter int unsigned TRIG_LEN   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ready,
    input  logic [CNT_W-1:0]      cfg_len,
    input  logic [WIN_W-1:0]      cfg_windows,
    input  logic                  pause,
    input  logic                  abort,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  trigger,
    output logic                  window_end,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    localparam int unsigned IDX_W = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1;
    localparam int unsigned CW1   = CNT_W + 1;
    localparam logic [CW1-1:0]   TRIG_LO        = CW1'(TRIG_START);
    localparam logic [CW1-1:0]   TRIG_HI        = CW1'(TRIG_START + TRIG_LEN);
    localparam logic [IDX_W-1:0] IDX_FILL_LAST  = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0] IDX_DRAIN_LAST = IDX_W'(NUM_STAGES - 2);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] run_q, run_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             aborted_q, aborted_d;

    logic             active_c;
    logic             timer_clear_c;
    logic             timer_en_c;
    logic             win_end_c;
    logic             last_c;
    logic [CNT_W-1:0] wcnt_c;
    logic [NUM_STAGES-1:0] therm_c;

    assign active_c      = (state_q == ST_FILL) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign timer_clear_c = ~active_c;
    assign timer_en_c    = active_c & ~pause;
    assign win_end_c     = active_c & last_c & ~pause;

    window_timer #(
        .CNT_W (CNT_W)
    ) u_window_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_c),
        .enable (timer_en_c),
        .length (len_q),
        .wcnt   (wcnt_c),
        .last   (last_c)
    );

    // Next-state logic and decoded outputs
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        win_d      = win_q;
        run_d      = run_q;
        idx_d      = idx_q;
        aborted_d  = aborted_q;
        ready      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        aborted    = 1'b0;
        stage_en   = '0;
        window_end = win_end_c;
        trigger    = active_c & ~pause & ({1'b0, wcnt_c} >= TRIG_LO) & ({1'b0, wcnt_c} < TRIG_HI);

        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            therm_c[i] = therm_bit(i, 32'(idx_q) + 32'd1);
        end

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (start) begin
                    len_d     = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
                    win_d     = cfg_windows;
                    idx_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                stage_en = therm_c;
                if (win_end_c) begin
                    if (idx_q == IDX_FILL_LAST) begin
                        idx_d   = '0;
                        run_d   = win_q;
                        state_d = (win_q != '0) ? ST_RUN : ST_DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                stage_en = '1;
                if (win_end_c) begin
                    run_d = run_q - WIN_W'(1);
                    if (run_q == WIN_W'(1)) begin
                        idx_d   = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                stage_en = ~therm_c;
                if (win_end_c) begin
                    if (idx_q == IDX_DRAIN_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                aborted = aborted_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // abort outranks pause and window completion
        if (active_c && abort) begin
            state_d   = ST_DONE;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= CNT_W'(1);
            win_q     <= '0;
            run_q     <= '0;
            idx_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            win_q     <= win_d;
            run_q     <= run_d;
            idx_q     <= idx_d;
            aborted_q <= aborted_d;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer with default parameters.
module tb_pipeline_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ready;
    logic [10:0] cfg_len;
    logic [15:0] cfg_windows;
    logic        pause;
    logic        abort;
    logic [4:0]  stage_en;
    logic        trigger;
    logic        window_end;
    logic        busy;
    logic        done;
    logic        aborted;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] t1_tbl [11] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                                5'b11111, 5'b11111,
                                5'b11110, 5'b11100, 5'b11000, 5'b10000};

    pipeline_sequencer #(
        .NUM_STAGES (5),
        .CNT_W      (11),
        .WIN_W      (16),
        .TRIG_START (1),
        .TRIG_LEN   (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ready       (ready),
        .cfg_len     (cfg_len),
        .cfg_windows (cfg_windows),
        .pause       (pause),
        .abort       (abort),
        .stage_en    (stage_en),
        .trigger     (trigger),
        .window_end  (window_end),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue start in the current (IDLE) cycle; returns in cycle 1 of the run.
    task automatic start_run(input logic [10:0] len, input logic [15:0] win);
        cfg_len     = len;
        cfg_windows = win;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    // Steps until done is seen; done_at is the cycle index of the DONE cycle, -1 on timeout.
    task automatic run_until_done(input int c0, input int budget, output int done_at, output int trigs);
        int c;
        c       = c0;
        done_at = -1;
        trigs   = 0;
        while (c < c0 + budget) begin
            if (done) begin
                done_at = c;
                break;
            end
            if (trigger) trigs++;
            step();
            c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at;
        int trigs;
        int t1_trigs;

        reset       = 1'b1;
        start       = 1'b0;
        cfg_len     = '0;
        cfg_windows = '0;
        pause       = 1'b0;
        abort       = 1'b0;
        #12;
        check("rst_ready",    32'(ready),      32'd1);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_stage_en", 32'(stage_en),   32'd0);
        check("rst_trigger",  32'(trigger),    32'd0);
        check("rst_win_end",  32'(window_end), 32'd0);
        check("rst_done",     32'(done),       32'd0);
        check("rst_aborted",  32'(aborted),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Nominal run: L=4, W=2
        start_run(11'd4, 16'd2);
        t1_trigs = 0;
        for (int c = 1; c <= 44; c++) begin
            check($sformatf("t1_stage_c%0d", c), 32'(stage_en), 32'(t1_tbl[(c - 1) / 4]));
            check($sformatf("t1_trig_c%0d", c), 32'(trigger), 32'(((c - 1) % 4) >= 1));
            check($sformatf("t1_wend_c%0d", c), 32'(window_end), 32'(((c - 1) % 4) == 3));
            check($sformatf("t1_done_c%0d", c), 32'(done), 32'd0);
            if (trigger) t1_trigs++;
            step();
        end
        check("t1_done45",    32'(done),     32'd1);
        check("t1_aborted",   32'(aborted),  32'd0);
        check("t1_stage_off", 32'(stage_en), 32'd0);
        check("t1_busy_done", 32'(busy),     32'd1);
        check("t1_trig_total", 32'(t1_trigs), 32'd33);
        step();
        check("t1_ready_after", 32'(ready), 32'd1);
        check("t1_done_after",  32'(done),  32'd0);

        // L=1, W=0: RUN skipped, no trigger
        start_run(11'd1, 16'd0);
        check("t2_stage_c1", 32'(stage_en), 32'b00001);
        run_until_done(1, 50, done_at, trigs);
        check("t2_done_at", 32'(done_at), 32'd10);
        check("t2_trigs",   32'(trigs),   32'd0);
        check("t2_aborted", 32'(aborted), 32'd0);
        step();

        // cfg_len=0 behaves as L=1
        start_run(11'd0, 16'd0);
        check("t6_stage_c1", 32'(stage_en), 32'b00001);
        step();
        check("t6_stage_c2", 32'(stage_en), 32'b00011);
        run_until_done(2, 50, done_at, trigs);
        check("t6_done_at", 32'(done_at), 32'd10);
        check("t6_trigs",   32'(trigs),   32'd0);
        step();

        // Pause for 7 cycles mid-RUN at wcnt=2
        start_run(11'd4, 16'd2);
        repeat (22) step();
        check("t3_pre_stage", 32'(stage_en), 32'b11111);
        check("t3_pre_trig",  32'(trigger),  32'd1);
        pause = 1'b1;
        #1;
        check("t3_p_trig0", 32'(trigger),    32'd0);
        check("t3_p_wend0", 32'(window_end), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("t3_p_stage%0d", k), 32'(stage_en),   32'b11111);
            check($sformatf("t3_p_trig%0d", k),  32'(trigger),    32'd0);
            check($sformatf("t3_p_wend%0d", k),  32'(window_end), 32'd0);
        end
        step();
        pause = 1'b0;
        #1;
        check("t3_resume_trig", 32'(trigger),    32'd1);
        check("t3_resume_wend", 32'(window_end), 32'd0);
        run_until_done(30, 100, done_at, trigs);
        check("t3_done_at", 32'(done_at), 32'd52);
        step();

        // Abort during FILL at idx=2
        start_run(11'd4, 16'd2);
        repeat (8) step();
        check("t4_pre_stage", 32'(stage_en), 32'b00111);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_done",    32'(done),     32'd1);
        check("t4_aborted", 32'(aborted),  32'd1);
        check("t4_stage",   32'(stage_en), 32'd0);
        check("t4_busy",    32'(busy),     32'd1);
        step();
        check("t4_ready", 32'(ready), 32'd1);
        check("t4_done0", 32'(done),  32'd0);
        abort = 1'b1;
        step();
        step();
        check("t4_idle_abort_ready", 32'(ready), 32'd1);
        check("t4_idle_abort_done",  32'(done),  32'd0);
        check("t4_idle_abort_busy",  32'(busy),  32'd0);
        abort = 1'b0;

        // start and cfg changes while busy are ignored
        start_run(11'd4, 16'd2);
        repeat (4) step();
        start       = 1'b1;
        cfg_len     = 11'd7;
        cfg_windows = 16'd9;
        repeat (3) step();
        start = 1'b0;
        check("t5_stage_c8", 32'(stage_en), 32'b00011);
        run_until_done(8, 100, done_at, trigs);
        check("t5_done_at",  32'(done_at), 32'd45);
        check("t5_aborted",  32'(aborted), 32'd0);
        step();

        // Asynchronous reset mid-DRAIN
        start_run(11'd4, 16'd2);
        repeat (37) step();
        check("t7_pre_stage", 32'(stage_en), 32'b11000);
        #2;
        reset = 1'b1;
        #1;
        check("t7_stage",   32'(stage_en),   32'd0);
        check("t7_busy",    32'(busy),       32'd0);
        check("t7_ready",   32'(ready),      32'd1);
        check("t7_trigger", 32'(trigger),    32'd0);
        check("t7_wend",    32'(window_end), 32'd0);
        check("t7_done",    32'(done),       32'd0);
        #1;
        reset = 1'b0;
        step();
        check("t7_post_ready", 32'(ready),    32'd1);
        check("t7_post_stage", 32'(stage_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Parametrised successor to the fixed five-stage link-test controller.
- Sequences NUM_STAGES pipeline enables (generator -> encoder -> bus -> decoder -> counters ...) in three phases:
  - fill: enables turn on one stage per window.
  - run: a programmable number of steady-state windows, all stages on.
  - drain: stages turn off from the front.
- Window length is programmable per run. Supports pause and abort, and reports completion status.
- Sits at the top of the test harness and drives the enables of the data generator, encoder, bus model, decoder and transition counters.

Parameters:
- NUM_STAGES, 5, number of stage enables (>=2).
- CNT_W, 11, width of the window-length counter.
- WIN_W, 16, width of the run-window count.
- TRIG_START, 1, first in-window cycle index with trigger high.
- TRIG_LEN, 3, number of trigger-high cycles per window (TRIG_START+TRIG_LEN <= 2^CNT_W).

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, request a run; accepted only when ready=1.
- ready, out, 1, high in IDLE.
- cfg_len, in, CNT_W, window length L in cycles; sampled on accept; 0 is treated as 1.
- cfg_windows, in, WIN_W, number of RUN windows W; sampled on accept; 0 skips RUN.
- pause, in, 1, freezes the sequence while high.
- abort, in, 1, terminates an active run.
- stage_en, out, NUM_STAGES, stage enables; bit 0 is the first stage.
- trigger, out, 1, per-window trigger strobe.
- window_end, out, 1, one-cycle pulse on the last cycle of each window.
- busy, out, 1, high in FILL/RUN/DRAIN/DONE.
- done, out, 1, one-cycle completion pulse.
- aborted, out, 1, qualifies done: 1 means the run ended by abort.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all counters 0.
  - stage_en=0, trigger=0, window_end=0, busy=0, done=0, aborted=0, ready=1.
- States: IDLE, FILL, RUN, DRAIN, DONE. All outputs decode from registered state/counters; no input-to-output combinational path except the pause gating of trigger/window_end.
- Accept:
  - Condition: start=1 in IDLE.
  - Action: latch L=max(cfg_len,1) and W=cfg_windows; wcnt=0; idx=0; next state FILL.
  - First FILL cycle is the cycle after accept. start in any other state is ignored.
- Window counter:
  - wcnt counts 0..L-1 in FILL/RUN/DRAIN.
  - window_end = (wcnt==L-1) & ~pause.
  - On window_end, wcnt returns to 0.
- FILL:
  - stage_en = thermometer of idx+1 low bits set.
  - On window_end: if idx==NUM_STAGES-1, go to RUN (W>0) or DRAIN (W==0) with idx=0 and the run counter loaded with W; otherwise idx++.
- RUN:
  - stage_en = all ones.
  - On window_end: decrement the run counter; at 1 -> go to DRAIN, idx=0.
- DRAIN:
  - stage_en = all ones with the low idx+1 bits cleared.
  - On window_end: if idx==NUM_STAGES-2 go to DONE, else idx++.
- DONE:
  - Lasts exactly one cycle: stage_en=0, done=1, busy=1.
  - Next state IDLE.
- trigger: 1 when in FILL/RUN/DRAIN, ~pause, and TRIG_START <= wcnt < TRIG_START+TRIG_LEN. If L <= TRIG_START, trigger never fires.
- Nominal run length: (2*NUM_STAGES-1+W)*L cycles of FILL/RUN/DRAIN, then 1 DONE cycle.
- pause in FILL/RUN/DRAIN:
  - wcnt, idx, run counter and state hold; stage_en holds.
  - trigger and window_end are forced 0.
  - pause in IDLE/DONE has no effect.
- abort:
  - In FILL/RUN/DRAIN: next state DONE regardless of pause or window_end (abort has highest priority).
  - aborted=1 during that DONE cycle; aborted=0 on normal completion.
  - abort in IDLE/DONE is ignored.
- The run counter never wraps; W up to 2^WIN_W-1 is supported.

Decomposition:
- Shared package pipeline_seq_pkg:
  - State enum (IDLE=0, FILL=1, RUN=2, DRAIN=3, DONE=4; 3-bit encoding).
  - Thermometer/mask helper function.
- One natural sub-module: window_timer.
  - Parametrised by CNT_W.
  - Inputs: clear, enable, length.
  - Outputs: wcnt, last.
  - Reused by the transition-counter block.

Test Plan:
- Defaults, cfg_len=4, cfg_windows=2, start pulse:
  - stage_en steps 00001, 00011, 00111, 01111, 11111 (one window each), then 11111 for 2 windows.
  - Then 11110, 11100, 11000, 10000.
  - done=1 with aborted=0 exactly 45 cycles after the accept cycle.
  - trigger high on wcnt=1..3 of every window (33 trigger cycles total).
- cfg_windows=0, cfg_len=1:
  - RUN is skipped; each window is 1 cycle.
  - done 10 cycles after accept.
  - trigger is never high (L <= TRIG_START).
- pause held 7 cycles mid-RUN at wcnt=2:
  - stage_en, wcnt and state frozen; trigger=0 during the pause.
  - done delayed by exactly 7 cycles versus the unpaused run.
- abort during FILL at idx=2:
  - next cycle state=DONE, stage_en=0, done=1, aborted=1.
  - Following cycle ready=1. abort asserted in IDLE has no effect.
- start asserted while busy, plus cfg_len changed mid-run:
  - Ignored; timing is unchanged.
  - Asynchronous reset asserted mid-DRAIN: all outputs reach reset values immediately, without waiting for a clk edge.
- cfg_len=0: behaves identically to cfg_len=1.
